// File: rtl/dla_hld_ram_read_credit_buffer.sv
// -----------------------------------------------------------------------------
// dla_hld_ram_read_credit_buffer
//
// Read-side front end for one port of a depth-stitched dual-port RAM.
// Accepts a valid/ready address stream and issues single-cycle reads to the RAM.
// The RAM has a fixed READ_LATENCY. Returned words are captured in a small
// response FIFO. A request is accepted only while a credit is free. A credit is
// a FIFO slot not already claimed by a buffered word or a read in flight. So a
// downstream stall can never drop a returning word.
//
// Optional feature (compile-time macro DLA_HLD_RAM_READ_CREDIT_BUFFER_BYPASS_EN):
//   When defined, a word returning into an empty FIFO is presented on rsp_*
//   combinationally in the same cycle. If it is accepted there, it never enters
//   the FIFO. When undefined, rsp_* come only from registers and FIFO storage.
//
// Ports:
//   clock            in   sole clock
//   reset            in   asynchronous, active-high reset
//   req_valid        in   read request present
//   req_ready        out  request accepted when req_valid && req_ready
//   req_address      in   logical read address
//   ram_address      out  address to RAM port
//   ram_read_enable  out  read strobe to RAM port
//   ram_in_clock_en  out  constant 1
//   ram_out_clock_en out  constant 1
//   ram_readdata     in   RAM data, valid READ_LATENCY clocks after the strobe
//   rsp_valid        out  response word available
//   rsp_ready        in   downstream accepts response
//   rsp_data         out  response word (0 while nothing is available)
//   outstanding      out  in-flight reads plus buffered words
// -----------------------------------------------------------------------------
module dla_hld_ram_read_credit_buffer #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 3,
  parameter int BUFFER_DEPTH = 5
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [ADDR_WIDTH-1:0]                 req_address,
  output logic [ADDR_WIDTH-1:0]                 ram_address,
  output logic                                  ram_read_enable,
  output logic                                  ram_in_clock_en,
  output logic                                  ram_out_clock_en,
  input  logic [DATA_WIDTH-1:0]                 ram_readdata,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic [DATA_WIDTH-1:0]                 rsp_data,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]     outstanding
);

  localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
  localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(BUFFER_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUFFER_DEPTH - 1);

  logic [CNT_W-1:0]        r_outstanding;
  logic [CNT_W-1:0]        r_count;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [READ_LATENCY-1:0] r_valid_pipe;
  logic [DATA_WIDTH-1:0]   r_mem [BUFFER_DEPTH];

  logic                    w_issue;
  logic                    w_pop;
  logic                    w_last;
  logic                    w_fifo_empty;
  logic                    w_fifo_wr;
  logic                    w_fifo_rd;
  logic [DATA_WIDTH-1:0]   w_head;

  // Credit check uses only the registered count. That keeps rsp_ready off the
  // combinational path to req_ready.
  assign req_ready        = !reset && (r_outstanding < DEPTH_C);
  assign w_issue          = req_valid && req_ready;
  assign ram_read_enable  = w_issue;
  assign ram_address      = req_address;
  assign ram_in_clock_en  = 1'b1;
  assign ram_out_clock_en = 1'b1;
  assign outstanding      = r_outstanding;

  assign w_last       = r_valid_pipe[READ_LATENCY-1];
  assign w_fifo_empty = (r_count == '0);
  assign w_head       = r_mem[r_rd_ptr];

`ifdef DLA_HLD_RAM_READ_CREDIT_BUFFER_BYPASS_EN
  // An empty FIFO lets the returning word through directly. The word is stored
  // only when the consumer does not take it this cycle.
  assign rsp_valid = !w_fifo_empty || w_last;
  assign rsp_data  = !w_fifo_empty ? w_head : (w_last ? ram_readdata : '0);
  assign w_fifo_wr = w_last && !(w_fifo_empty && rsp_ready);
`else
  assign rsp_valid = !w_fifo_empty;
  assign rsp_data  = w_fifo_empty ? '0 : w_head;
  assign w_fifo_wr = w_last;
`endif

  assign w_pop     = rsp_valid && rsp_ready;
  // A bypassed pop does not touch FIFO storage.
  assign w_fifo_rd = w_pop && !w_fifo_empty;

  // This shift register mirrors the RAM's read latency. It marks which cycles
  // carry real data on ram_readdata.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid_pipe <= '0;
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        r_valid_pipe[i] <= r_valid_pipe[i-1];
      end
      r_valid_pipe[0] <= w_issue;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_outstanding <= '0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else begin
      r_outstanding <= r_outstanding + CNT_W'(w_issue) - CNT_W'(w_pop);
      r_count       <= r_count + CNT_W'(w_fifo_wr) - CNT_W'(w_fifo_rd);
      // Explicit wrap so that non-power-of-two depths work.
      if (w_fifo_wr) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_fifo_rd) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
      end
    end
  end

  // Storage is left unreset. Its contents are only observed behind r_count.
  always_ff @(posedge clock) begin
    if (w_fifo_wr) begin
      r_mem[r_wr_ptr] <= ram_readdata;
    end
  end

  // Credit invariants. Any firing here means the credit accounting is broken.
  always @(posedge clock) begin
    if (!reset) begin
      assert (!(w_fifo_wr && (r_count == DEPTH_C)));
      assert (!(w_issue && !w_pop && (r_outstanding == DEPTH_C)));
      assert (!(w_pop && !w_issue && (r_outstanding == '0)));
    end
  end

endmodule
